// File: rtl/unit3_issue_pkg.sv
// Purpose : shared types and constants for the unit-3 issue stage.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package unit3_issue_pkg;

    typedef enum logic [1:0] {
        CLS_NOP = 2'd0,
        CLS_ALU = 2'd1,
        CLS_FPU = 2'd2
    } cls_e;

    typedef struct packed {
        logic [5:0]  ope;
        logic [3:0]  ctrl;
        logic [5:0]  ds;
        logic [5:0]  dt;
        logic [5:0]  dd;
        logic [15:0] imm;
    } entry_t;

    localparam int         ENTRY_W      = $bits(entry_t);
    // Low opcode bits that mark a real ALU operation.
    localparam logic [1:0] OPE_ALU_MASK = 2'b00;
    localparam int         BUSY_ALU     = 0;
    localparam int         BUSY_FPU     = 1;

    // Any non-zero FPU control wins over the opcode.
    function automatic cls_e classify(input entry_t e);
        if (e.ctrl != 4'd0) begin
            return CLS_FPU;
        end
        if (e.ope != 6'd0 && e.ope[1:0] == OPE_ALU_MASK) begin
            return CLS_ALU;
        end
        return CLS_NOP;
    endfunction

    // FPU ops always read t; ALU ops only when opcode bit 2 is set.
    function automatic logic uses_dt(input entry_t e, input cls_e c);
        return (c == CLS_FPU) || (c == CLS_ALU && e.ope[2]);
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Purpose : generic synchronous FIFO with head peek (instruction queue).
// Latency : pushed word visible at head the cycle after the push edge.
// Backpressure: full_o blocks push; push and pop together are fine when not full.
// Ports   : push_i/push_dat_i write side, pop_i/head_dat_o read side, full_o/empty_o status.
module issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_dat_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    // Storage needs no reset: empty_o masks stale words.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (!push_ok && pop_ok) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/unit3_issue.sv
// Purpose : in-order issue of ALU/FPU ops to unit 3 with scoreboard hazard checks.
// Latency : accepted at E0, earliest issue pulse on the operand bus after E1, one cycle wide.
// Backpressure: in_ready = queue not full; a stalled head blocks every younger entry.
// Ports   : in_* decoded instruction in (valid/ready); rf_* same-cycle register read;
//           is_busy unit stall bits; wb_* writeback ids; ope/ctrl/ds_val/dt_val/dd/imm issue bus.
module unit3_issue
    import unit3_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NREG  = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_ope,
    input  logic [3:0]  in_ctrl,
    input  logic [5:0]  in_ds,
    input  logic [5:0]  in_dt,
    input  logic [5:0]  in_dd,
    input  logic [15:0] in_imm,
    output logic [5:0]  rf_ds_addr,
    output logic [5:0]  rf_dt_addr,
    input  logic [31:0] rf_ds_val,
    input  logic [31:0] rf_dt_val,
    input  logic [6:0]  is_busy,
    input  logic [5:0]  wb_alu_addr,
    input  logic [5:0]  wb_fpu_addr,
    output logic [5:0]  ope,
    output logic [3:0]  ctrl,
    output logic [31:0] ds_val,
    output logic [31:0] dt_val,
    output logic [5:0]  dd,
    output logic [15:0] imm
);
    entry_t             in_ent;
    entry_t             head;
    logic [ENTRY_W-1:0] head_dat;
    logic               fifo_full;
    logic               fifo_empty;
    logic               head_vld;
    cls_e               head_cls;
    logic               hazard;
    logic               do_issue;
    logic               do_pop;
    logic [NREG-1:0]    pending_q, pending_d;
    logic [5:0]         ope_q, ope_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [31:0]        ds_val_q, ds_val_d;
    logic [31:0]        dt_val_q, dt_val_d;
    logic [5:0]         dd_q, dd_d;
    logic [15:0]        imm_q, imm_d;
    logic               unused_busy;

    assign unused_busy = ^is_busy[6:2];

    assign in_ent = '{ope: in_ope, ctrl: in_ctrl, ds: in_ds, dt: in_dt, dd: in_dd, imm: in_imm};
    assign in_ready = !fifo_full;

    issue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (in_valid),
        .push_dat_i (in_ent),
        .pop_i      (do_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_dat_o (head_dat)
    );

    assign head     = entry_t'(head_dat);
    assign head_vld = !fifo_empty;

    // Address 0 while empty so the register file sees a quiet bus.
    assign rf_ds_addr = head_vld ? head.ds : 6'd0;
    assign rf_dt_addr = head_vld ? head.dt : 6'd0;

    always_comb begin
        head_cls = classify(head);
        hazard   = pending_q[head.ds]
                || (uses_dt(head, head_cls) && pending_q[head.dt])
                || (head.dd != 6'd0 && pending_q[head.dd])
                || (head_cls == CLS_ALU && is_busy[BUSY_ALU])
                || (head_cls == CLS_FPU && is_busy[BUSY_FPU]);
        do_issue = head_vld && (head_cls != CLS_NOP) && !hazard;
        // NOP heads drain without touching the bus or the scoreboard.
        do_pop   = head_vld && ((head_cls == CLS_NOP) || !hazard);
    end

    // Clear before set: a set id is never pending, so order only matters
    // for a stray writeback naming an idle id.
    always_comb begin
        pending_d = pending_q;
        if (wb_alu_addr != 6'd0) begin
            pending_d[wb_alu_addr] = 1'b0;
        end
        if (wb_fpu_addr != 6'd0) begin
            pending_d[wb_fpu_addr] = 1'b0;
        end
        if (do_issue && head.dd != 6'd0) begin
            pending_d[head.dd] = 1'b1;
        end
    end

    always_comb begin
        ope_d    = 6'd0;
        ctrl_d   = 4'd0;
        ds_val_d = 32'd0;
        dt_val_d = 32'd0;
        dd_d     = 6'd0;
        imm_d    = 16'd0;
        if (do_issue) begin
            ope_d    = head.ope;
            ctrl_d   = head.ctrl;
            ds_val_d = rf_ds_val;
            dt_val_d = rf_dt_val;
            dd_d     = head.dd;
            imm_d    = head.imm;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= '0;
            ope_q     <= '0;
            ctrl_q    <= '0;
            ds_val_q  <= '0;
            dt_val_q  <= '0;
            dd_q      <= '0;
            imm_q     <= '0;
        end else begin
            pending_q <= pending_d;
            ope_q     <= ope_d;
            ctrl_q    <= ctrl_d;
            ds_val_q  <= ds_val_d;
            dt_val_q  <= dt_val_d;
            dd_q      <= dd_d;
            imm_q     <= imm_d;
        end
    end

    assign ope    = ope_q;
    assign ctrl   = ctrl_q;
    assign ds_val = ds_val_q;
    assign dt_val = dt_val_q;
    assign dd     = dd_q;
    assign imm    = imm_q;

endmodule

// File: tb/tb_unit3_issue.sv
// Purpose : self-checking bench for unit3_issue (vector table, directed corners, random vs model).
// Latency : n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_unit3_issue;
    import unit3_issue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_ope = '0;
    logic [3:0]  in_ctrl = '0;
    logic [5:0]  in_ds = '0, in_dt = '0, in_dd = '0;
    logic [15:0] in_imm = '0;
    logic [5:0]  rf_ds_addr, rf_dt_addr;
    logic [31:0] rf_ds_val, rf_dt_val;
    logic [6:0]  is_busy = '0;
    logic [5:0]  wb_alu_addr = '0, wb_fpu_addr = '0;
    logic [5:0]  ope;
    logic [3:0]  ctrl;
    logic [31:0] ds_val, dt_val;
    logic [5:0]  dd;
    logic [15:0] imm;

    always #5 clk = ~clk;

    unit3_issue #(.DEPTH(DEPTH), .NREG(64)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_ope(in_ope), .in_ctrl(in_ctrl), .in_ds(in_ds), .in_dt(in_dt), .in_dd(in_dd), .in_imm(in_imm),
        .rf_ds_addr(rf_ds_addr), .rf_dt_addr(rf_dt_addr), .rf_ds_val(rf_ds_val), .rf_dt_val(rf_dt_val),
        .is_busy(is_busy), .wb_alu_addr(wb_alu_addr), .wb_fpu_addr(wb_fpu_addr),
        .ope(ope), .ctrl(ctrl), .ds_val(ds_val), .dt_val(dt_val), .dd(dd), .imm(imm)
    );

    // Register file: register i holds i*10.
    logic [31:0] rf_mem [64];
    always_comb begin
        rf_ds_val = rf_mem[rf_ds_addr];
        rf_dt_val = rf_mem[rf_dt_addr];
    end

    // Reference model: queue of waiting instructions plus a pending-id bitmap.
    entry_t     mq[$];
    bit [63:0]  mpend;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic [5:0] o, input logic [3:0] c, input logic [5:0] s,
                                  input logic [5:0] t, input logic [5:0] d, input logic [15:0] i);
        entry_t e;
        e.ope = o; e.ctrl = c; e.ds = s; e.dt = t; e.dd = d; e.imm = i;
        return e;
    endfunction

    task automatic set_in(input bit v, input entry_t e, input logic [6:0] b,
                          input logic [5:0] wa, input logic [5:0] wf);
        in_valid = v; in_ope = e.ope; in_ctrl = e.ctrl; in_ds = e.ds; in_dt = e.dt;
        in_dd = e.dd; in_imm = e.imm; is_busy = b; wb_alu_addr = wa; wb_fpu_addr = wf;
    endtask

    task automatic idle(input logic [6:0] b);
        set_in(1'b0, mk(0, 0, 0, 0, 0, 0), b, 6'd0, 6'd0);
    endtask

    // One clock: checks ready/read addresses before the edge, then the issue bus after it.
    task automatic run_cycle(output bit issued);
        entry_t      h;
        entry_t      cur;
        bit          fpu, alu, haz, pop, rdy;
        logic [95:0] exp_out;
        #2;
        rdy = (mq.size() < DEPTH);
        chk("in_ready", in_ready, rdy);
        issued = 0; pop = 0; exp_out = '0; h = mk(0, 0, 0, 0, 0, 0);
        if (mq.size() != 0) begin
            h = mq[0];
            chk("rf_addr", {rf_ds_addr, rf_dt_addr}, {h.ds, h.dt});
            fpu = (h.ctrl != 0);
            alu = !fpu && (h.ope != 0) && (h.ope % 4 == 0);
            if (!fpu && !alu) begin
                pop = 1;
            end else begin
                haz = mpend[h.ds] || ((fpu || h.ope[2]) && mpend[h.dt])
                   || (h.dd != 0 && mpend[h.dd]) || (alu ? is_busy[0] : is_busy[1]);
                if (!haz) begin
                    issued = 1; pop = 1;
                    exp_out = {h.ope, h.ctrl, h.dd, h.imm, rf_mem[h.ds], rf_mem[h.dt]};
                end
            end
        end else begin
            chk("rf_addr_idle", {rf_ds_addr, rf_dt_addr}, 12'd0);
        end
        cur = mk(in_ope, in_ctrl, in_ds, in_dt, in_dd, in_imm);
        if (pop) void'(mq.pop_front());
        if (in_valid && rdy) mq.push_back(cur);
        if (wb_alu_addr != 0) mpend[wb_alu_addr] = 0;
        if (wb_fpu_addr != 0) mpend[wb_fpu_addr] = 0;
        if (issued && h.dd != 0) mpend[h.dd] = 1;
        @(posedge clk);
        #1;
        chk("issue_bus", {ope, ctrl, dd, imm, ds_val, dt_val}, exp_out);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(7'd0);
        wb_fpu_addr = 6'd5;
        #1;
        chk("rst_bus", {ope, ctrl, dd, imm, ds_val, dt_val}, 96'd0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_rfaddr", {rf_ds_addr, rf_dt_addr}, 12'd0);
        mq.delete();
        mpend = '0;
        repeat (2) @(posedge clk);
        #1;
        wb_fpu_addr = 6'd0;
        rstn = 1'b1;
    endtask

    function automatic logic [5:0] rid();
        int r;
        r = $urandom_range(0, 9);
        return (r < 6) ? 6'(r) : 6'(r + 26);
    endfunction

    function automatic logic [5:0] pick_pending();
        int s;
        if ($urandom_range(0, 2) != 0) return 6'd0;
        s = $urandom_range(0, 63);
        for (int k = 0; k < 64; k++) begin
            if (mpend[(s + k) % 64]) return 6'((s + k) % 64);
        end
        return 6'd0;
    endfunction

    typedef struct {
        logic        v;
        entry_t      e;
        logic [6:0]  busy;
        logic [5:0]  wba;
        logic [5:0]  exp_ope;
        logic [5:0]  exp_dd;
        logic [31:0] exp_ds;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit iss;
        for (int i = 0; i < 64; i++) rf_mem[i] = 32'(i * 10);

        // Basic issue and RAW on id 3 cleared by an ALU writeback.
        tbl[0] = '{1'b1, mk(6'b001100, 0, 1, 2, 3, 16'h0005), 7'd0, 6'd0, 6'd0,  6'd0, 32'd0};
        tbl[1] = '{1'b1, mk(6'b001100, 0, 3, 0, 4, 16'h0007), 7'd0, 6'd0, 6'd12, 6'd3, 32'd10};
        tbl[2] = '{1'b0, mk(0, 0, 0, 0, 0, 0),                7'd0, 6'd0, 6'd0,  6'd0, 32'd0};
        tbl[3] = '{1'b0, mk(0, 0, 0, 0, 0, 0),                7'd0, 6'd0, 6'd0,  6'd0, 32'd0};
        tbl[4] = '{1'b0, mk(0, 0, 0, 0, 0, 0),                7'd0, 6'd3, 6'd0,  6'd0, 32'd0};
        tbl[5] = '{1'b0, mk(0, 0, 0, 0, 0, 0),                7'd0, 6'd0, 6'd12, 6'd4, 32'd30};
        tbl[6] = '{1'b0, mk(0, 0, 0, 0, 0, 0),                7'd0, 6'd0, 6'd0,  6'd0, 32'd0};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i].v, tbl[i].e, tbl[i].busy, tbl[i].wba, 6'd0);
            run_cycle(iss);
            chk($sformatf("tbl%0d_ope", i), ope, tbl[i].exp_ope);
            chk($sformatf("tbl%0d_dd", i), dd, tbl[i].exp_dd);
            chk($sformatf("tbl%0d_ds", i), ds_val, tbl[i].exp_ds);
        end

        // Fill the queue behind a busy ALU, then drain back to back.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, mk(6'd4, 0, 6'(10 + i), 0, 6'(20 + i), 16'(i)), 7'd1, 6'd0, 6'd0);
            run_cycle(iss);
        end
        chk("full_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_in(i == 0, mk(6'd4, 0, 6'd1, 0, 6'd30, 0), 7'd0, 6'd0, 6'd0);
            run_cycle(iss);
            chk($sformatf("drain%0d_dd", i), dd, 6'(20 + i));
            if (i == 0) chk("ready_after_pop", in_ready, 1'b1);
        end
        idle(7'd0);
        run_cycle(iss);
        chk("drain_bubble", ope, 6'd0);

        // FPU head held by FPU busy; ALU op behind it waits its turn.
        do_reset();
        set_in(1'b1, mk(6'd0, 4'd1, 6'd33, 6'd34, 6'd35, 16'h0011), 7'd2, 6'd0, 6'd0);
        run_cycle(iss);
        set_in(1'b1, mk(6'd12, 4'd0, 6'd1, 6'd2, 6'd6, 16'h0009), 7'd2, 6'd0, 6'd0);
        run_cycle(iss);
        chk("fpu_busy1", ctrl, 4'd0);
        idle(7'd2);
        run_cycle(iss);
        chk("fpu_busy2", {ope, ctrl}, 10'd0);
        idle(7'd0);
        run_cycle(iss);
        chk("fpu_issue", {ctrl, dd}, {4'd1, 6'd35});
        chk("fpu_dt_val", dt_val, 32'd340);
        idle(7'd0);
        run_cycle(iss);
        chk("alu_after_fpu", {ope, dd}, {6'd12, 6'd6});

        // NOP head drains silently; ALU op without t ignores a pending t.
        do_reset();
        set_in(1'b1, mk(6'd12, 0, 6'd1, 6'd2, 6'd9, 0), 7'd0, 6'd0, 6'd0);
        run_cycle(iss);
        set_in(1'b1, mk(6'b000001, 0, 6'd9, 6'd9, 6'd11, 0), 7'd0, 6'd0, 6'd0);
        run_cycle(iss);
        set_in(1'b1, mk(6'b001000, 0, 6'd0, 6'd9, 6'd10, 16'h0003), 7'd0, 6'd0, 6'd0);
        run_cycle(iss);
        chk("nop_no_pulse", {ope, dd}, 12'd0);
        set_in(1'b1, mk(6'd12, 0, 6'd11, 6'd0, 6'd12, 0), 7'd0, 6'd0, 6'd0);
        run_cycle(iss);
        chk("alu_no_dt", {ope, dd}, {6'd8, 6'd10});
        idle(7'd0);
        run_cycle(iss);
        chk("nop_no_sb", dd, 6'd12);

        // Reset with queued work and pending[5].
        do_reset();
        set_in(1'b1, mk(6'd0, 4'd2, 6'd33, 6'd34, 6'd5, 16'h00AA), 7'd2, 6'd0, 6'd0);
        run_cycle(iss);
        set_in(1'b1, mk(6'd4, 0, 6'd5, 0, 6'd7, 16'h0001), 7'd2, 6'd0, 6'd0);
        run_cycle(iss);
        set_in(1'b1, mk(6'd4, 0, 6'd1, 0, 6'd8, 16'h0002), 7'd2, 6'd0, 6'd0);
        run_cycle(iss);
        set_in(1'b1, mk(6'd4, 0, 6'd2, 0, 6'd13, 16'h0003), 7'd2, 6'd0, 6'd0);
        run_cycle(iss);
        idle(7'd1);
        run_cycle(iss);
        chk("pre_rst_issue", {ctrl, dd}, {4'd2, 6'd5});
        do_reset();
        set_in(1'b1, mk(6'd12, 0, 6'd5, 0, 6'd14, 0), 7'd0, 6'd0, 6'd0);
        run_cycle(iss);
        idle(7'd0);
        run_cycle(iss);
        chk("post_rst_issue", {dd, ds_val}, {6'd14, 32'd50});

        // Random traffic against the model, with one reset in the middle.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            entry_t      e;
            logic [5:0]  o, wa, wf;
            logic [3:0]  cf;
            int          r;
            r  = $urandom_range(0, 15);
            o  = (r < 10) ? 6'(r * 4) : 6'($urandom);
            cf = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            e  = mk(o, cf, rid(), rid(), rid(), 16'($urandom));
            wa = pick_pending();
            wf = ($urandom_range(0, 9) == 0) ? wa : pick_pending();
            set_in($urandom_range(0, 9) < 7, e,
                   {5'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0)},
                   wa, wf);
            run_cycle(iss);
            if (c == 300) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
